fb_write_ctrl: RTL and testbench

FB_WRITE_CTRL -- requirements
Module: fb_write_ctrl

---
 rtl/img_pkg.sv | 23 ++
 rtl/fb_write_ctrl_if.sv | 30 +++
 rtl/fb_write_ctrl_addr_gen.sv | 62 ++++++
 rtl/fb_write_ctrl.sv | 158 +++++++++++++++
 tb/tb_fb_write_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/img_pkg.sv
// Shared definitions for the frame-buffer write controller: image geometry
// defaults, bus widths and the controller state encoding.
package img_pkg;

    localparam int IMG_W_DEF = 103;   // valid pixels per row
    localparam int BUF_W_DEF = 110;   // buffer row stride in words
    localparam int IMG_H_DEF = 103;   // rows per frame
    localparam int ADDR_W    = 14;    // buffer write address width
    localparam int PIX_W     = 8;     // pixel width
    localparam int SUM_W     = 16;    // frame checksum width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Number of pixels that make up one complete frame.
    function automatic int frame_pixels(input int w, input int h);
        return w * h;
    endfunction

endpackage

// File: rtl/fb_write_ctrl_if.sv
// Pixel stream in and buffer write port out of the frame-buffer write
// controller, bundled so the producer and the controller share one bus.
//
// Handshake: valid_in qualifies pixel_in (and done_in is a standalone
// one-cycle pulse). There is no ready/backpressure: a pixel is taken on every
// rising edge where valid_in=1 and the controller is writing a frame. wr_en
// qualifies wr_addr/wr_data for exactly one cycle per taken pixel.
interface fb_write_ctrl_if;
    import img_pkg::*;

    logic [PIX_W-1:0]  pixel_in;
    logic              valid_in;
    logic              done_in;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;

    // Pixel producer side (filter / testbench).
    modport master (
        output pixel_in, valid_in, done_in,
        input  wr_en, wr_addr, wr_data
    );

    // Controller side.
    modport slave (
        input  pixel_in, valid_in, done_in,
        output wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/fb_write_ctrl_addr_gen.sv
// Buffer address generator: a column counter plus a row-base accumulator that
// steps by the row stride, so row*BUF_W+col is formed without a multiplier.
// The write strobe, address and data are registered, giving one cycle from an
// accepted pixel to its buffer write. Pad columns are never addressed because
// the column counter wraps at IMG_W-1.
module fbw_addr_gen
    import img_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int BUF_W = BUF_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,     // restart the frame at address 0
    input  logic              advance,   // a pixel was accepted this cycle
    input  logic [PIX_W-1:0]  pixel,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(BUF_W);

    logic [COL_W-1:0]  col;
    logic [ADDR_W-1:0] row_base;

    // Column / row-base position of the next pixel to be written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col      <= '0;
            row_base <= '0;
        end else if (clear) begin
            col      <= '0;
            row_base <= '0;
        end else if (advance) begin
            if (col == COL_LAST) begin
                col      <= '0;
                row_base <= row_base + STRIDE;
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Registered buffer write port, one cycle behind the accepted pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= advance;
            if (advance) begin
                wr_addr <= row_base + ADDR_W'(col);
                wr_data <= pixel;
            end
        end
    end

endmodule

// File: rtl/fb_write_ctrl.sv
// Frame-buffer write controller. Arms on start, writes each accepted pixel
// into a strided frame buffer, ends the frame on the last pixel or on the
// filter's done pulse, and reports frame_done plus sticky overrun/underrun.
// Optional build macro FBW_CHECKSUM_EN adds a mod-2^16 checksum of the
// pixels written in the current frame on frame_sum; without it frame_sum is 0.
module fb_write_ctrl
    import img_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int BUF_W = BUF_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    fb_write_ctrl_if.slave    px,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun,
    output logic              underrun,
    output logic [SUM_W-1:0]  frame_sum,
    output state_t            dbg_state
);

    localparam int TOTAL = frame_pixels(IMG_W, IMG_H);
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOTAL - 1);

    logic [1:0]       rst_sync;
    logic             rst_n;
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] pix_cnt;
    logic             start_idle;
    logic             restart;
    logic             accept;
    logic             last_pix;

    // Reset asserts immediately; release is synchronised through two flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    // A start in WRITE abandons the current frame; the pixel offered in that
    // same cycle belongs to the abandoned frame and is dropped.
    assign start_idle = start && (state == IDLE);
    assign restart    = start && (state == WRITE);
    assign accept     = (state == WRITE) && px.valid_in && !start;
    assign last_pix   = accept && (pix_cnt == CNT_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and state-decoded status outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                busy = 1'b1;
                if (!start && (last_pix || px.done_in)) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                frame_done = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign dbg_state = state;

    // Count of pixels accepted in the current frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt <= '0;
        end else if (start_idle || restart) begin
            pix_cnt <= '0;
        end else if (accept) begin
            pix_cnt <= pix_cnt + CNT_W'(1);
        end
    end

    // Sticky error flags; only a fresh start from IDLE clears them. A done
    // pulse that lands with the final pixel is a clean frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else if (start_idle) begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (px.valid_in && px.done_in && !last_pix) begin
                overrun <= 1'b1;
            end
            if ((state == WRITE) && px.done_in && !start && !last_pix) begin
                underrun <= 1'b1;
            end
        end
    end

`ifdef FBW_CHECKSUM_EN
    logic [SUM_W-1:0] sum_q;

    // Running checksum of the current frame; holds after the frame ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (start_idle || restart) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= sum_q + SUM_W'(px.pixel_in);
        end
    end

    assign frame_sum = sum_q;
`else
    assign frame_sum = '0;
`endif

    fbw_addr_gen #(
        .IMG_W (IMG_W),
        .BUF_W (BUF_W)
    ) u_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (start_idle || restart),
        .advance (accept),
        .pixel   (px.pixel_in),
        .wr_en   (px.wr_en),
        .wr_addr (px.wr_addr),
        .wr_data (px.wr_data)
    );

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Testbench for fb_write_ctrl: directed frames against a frame-level model
// of the write sequence and flags, with a per-cycle compare on the negedge.
module tb_fb_write_ctrl;
    import img_pkg::*;

    localparam int IMG_W = 103;
    localparam int BUF_W = 110;
    localparam int IMG_H = 103;
    localparam int TOTAL = IMG_W * IMG_H;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic        frame_done;
    logic        overrun;
    logic        underrun;
    logic [15:0] frame_sum;
    state_t      dbg_state;

    fb_write_ctrl_if bus();

    fb_write_ctrl #(
        .IMG_W (IMG_W),
        .BUF_W (BUF_W),
        .IMG_H (IMG_H)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .px         (bus),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun),
        .underrun   (underrun),
        .frame_sum  (frame_sum),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- model and scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    int          m_phase = 0;     // 0 idle, 1 writing a frame, 2 frame just ended
    int          m_n = 0;         // pixels accepted in the current frame
    bit          m_over = 0;
    bit          m_under = 0;
    bit          m_wr = 0;        // a buffer write is due this cycle
    logic [15:0] m_sum = '0;
    logic [21:0] exp_q[$];        // {addr, data} of writes still to appear
    int          seen_addr[$];    // addresses the DUT actually wrote
    int          fd_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame pixel index -> buffer word address, straight from the geometry.
    function automatic int model_addr(input int idx);
        return (idx / IMG_W) * BUF_W + (idx % IMG_W);
    endfunction

    // Effect of one clock edge with the given inputs on the frame model.
    task automatic model_edge(input bit s, input bit v, input logic [7:0] p, input bit d);
        bit acc;
        bit fin;
        acc  = (m_phase == 1) && v && !s;
        fin  = acc && (m_n == TOTAL - 1);
        m_wr = acc;
        if (acc) begin
            exp_q.push_back({14'(model_addr(m_n)), p});
            m_sum = m_sum + 16'(p);
            m_n++;
        end
        if (s && m_phase == 0) begin
            m_over  = 0;
            m_under = 0;
        end else begin
            if (v && d && !fin) m_over = 1;
            if (m_phase == 1 && d && !s && !fin) m_under = 1;
        end
        case (m_phase)
            0: if (s) begin m_phase = 1; m_n = 0; m_sum = '0; end
            1: begin
                if (s) begin m_n = 0; m_sum = '0; end
                else if (fin || d) m_phase = 2;
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_n     = 0;
        m_over  = 0;
        m_under = 0;
        m_wr    = 0;
        m_sum   = '0;
        exp_q.delete();
    endtask

    // Per-cycle compare of every DUT output against the model.
    always @(negedge clk) begin
        logic [21:0] e;
        check("wr_en", {31'd0, bus.wr_en}, {31'd0, m_wr});
        if (m_wr && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (bus.wr_en) begin
                check("wr_addr", 32'(bus.wr_addr), 32'(e[21:8]));
                check("wr_data", 32'(bus.wr_data), 32'(e[7:0]));
            end
        end
        if (bus.wr_en) seen_addr.push_back(int'(bus.wr_addr));
        check("busy", {31'd0, busy}, {31'd0, m_phase == 1});
        check("frame_done", {31'd0, frame_done}, {31'd0, m_phase == 2});
        check("overrun", {31'd0, overrun}, {31'd0, m_over});
        check("underrun", {31'd0, underrun}, {31'd0, m_under});
`ifdef FBW_CHECKSUM_EN
        check("frame_sum", 32'(frame_sum), 32'(m_sum));
`else
        check("frame_sum", 32'(frame_sum), 32'd0);
`endif
        if (frame_done) fd_count++;
    end

    // ---------------- driver tasks ----------------
    task automatic step(input bit s, input bit v, input logic [7:0] p, input bit d);
        start        = s;
        bus.valid_in = v;
        bus.pixel_in = p;
        bus.done_in  = d;
        @(posedge clk);
        #1;
        if (reset_n) model_edge(s, v, p, d);
        else m_wr = 0;
        start        = 1'b0;
        bus.valid_in = 1'b0;
        bus.done_in  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0);
    endtask

    // Send n pixels; ramp selects a varying pattern instead of constant 0x01,
    // gaps inserts random idle cycles between pixels.
    task automatic send_pixels(input int n, input bit ramp, input bit gaps);
        int i;
        i = 0;
        while (i < n) begin
            if (gaps && $urandom_range(0, 1) == 0) begin
                step(0, 0, 8'hee, 0);
            end else begin
                step(0, 1, ramp ? 8'(i * 7 + 3) : 8'h01, 0);
                i++;
            end
        end
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int fd0;
        bus.pixel_in = '0;
        bus.valid_in = 1'b0;
        bus.done_in  = 1'b0;
        reset_n      = 1'b0;
        idle(3);
        check("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_frame_sum", 32'(frame_sum), 32'd0);
        reset_n = 1'b1;
        idle(4);

        // Full frame of constant 0x01, no gaps.
        seen_addr.delete();
        fd0 = fd_count;
        step(1, 0, 8'h00, 0);
        send_pixels(TOTAL, 0, 0);
        idle(3);
        check("t1_first_addr", 32'(seen_addr[0]), 32'd0);
        check("t1_col102_row0", 32'(seen_addr[102]), 32'd102);
        check("t1_col0_row1", 32'(seen_addr[103]), 32'd110);
        check("t1_count", 32'(seen_addr.size()), 32'd10609);
        check("t1_last_addr", 32'(seen_addr[seen_addr.size() - 1]), 32'd11322);
        check("t1_frame_done", 32'(fd_count - fd0), 32'd1);
        check("t1_underrun", {31'd0, underrun}, 32'd0);
`ifdef FBW_CHECKSUM_EN
        check("t1_checksum", 32'(frame_sum), 32'h2971);
`endif

        // Full frame with random gaps and a ramp pattern.
        seen_addr.delete();
        fd0 = fd_count;
        step(1, 0, 8'h00, 0);
        send_pixels(TOTAL, 1, 1);
        idle(3);
        check("t2_count", 32'(seen_addr.size()), 32'd10609);
        check("t2_col0_row1", 32'(seen_addr[103]), 32'd110);
        check("t2_last_addr", 32'(seen_addr[seen_addr.size() - 1]), 32'd11322);
        check("t2_frame_done", 32'(fd_count - fd0), 32'd1);

        // Early done: underrun, then cleared by a start from IDLE.
        seen_addr.delete();
        fd0 = fd_count;
        step(1, 0, 8'h00, 0);
        send_pixels(500, 1, 0);
        step(0, 0, 8'h00, 1);
        idle(3);
        check("t3_underrun", {31'd0, underrun}, 32'd1);
        check("t3_frame_done", 32'(fd_count - fd0), 32'd1);
        check("t3_count", 32'(seen_addr.size()), 32'd500);
        seen_addr.delete();
        fd0 = fd_count;
        step(1, 0, 8'h00, 0);
        check("t3_underrun_cleared", {31'd0, underrun}, 32'd0);
        check("t3_busy", {31'd0, busy}, 32'd1);

        // done_in together with the final pixel, then a stray pixel+done.
        send_pixels(TOTAL - 1, 0, 0);
        step(0, 1, 8'h01, 1);
        idle(3);
        check("t4_last_addr", 32'(seen_addr[seen_addr.size() - 1]), 32'd11322);
        check("t4_count", 32'(seen_addr.size()), 32'd10609);
        check("t4_overrun", {31'd0, overrun}, 32'd0);
        check("t4_underrun", {31'd0, underrun}, 32'd0);
        check("t4_frame_done", 32'(fd_count - fd0), 32'd1);
        step(0, 1, 8'h09, 1);
        idle(1);
        check("t4_late_overrun", {31'd0, overrun}, 32'd1);

        // Restart mid-frame: new frame from address 0, one frame_done total.
        fd0 = fd_count;
        step(1, 0, 8'h00, 0);
        check("t5_overrun_cleared", {31'd0, overrun}, 32'd0);
        send_pixels(3000, 1, 0);
        step(1, 0, 8'h00, 0);
        seen_addr.delete();
        send_pixels(TOTAL - 1, 1, 0);
        check("t5_no_early_done", 32'(fd_count - fd0), 32'd0);
        send_pixels(1, 0, 0);
        idle(3);
        check("t5_restart_addr", 32'(seen_addr[0]), 32'd0);
        check("t5_count", 32'(seen_addr.size()), 32'd10609);
        check("t5_frame_done", 32'(fd_count - fd0), 32'd1);

        // Reset in mid-frame: outputs drop at once, valid_in ignored after.
        step(1, 0, 8'h00, 0);
        send_pixels(200, 1, 0);
        reset_n = 1'b0;
        #1;
        check("t6_wr_en_async", {31'd0, bus.wr_en}, 32'd0);
        check("t6_busy_async", {31'd0, busy}, 32'd0);
        model_reset();
        step(0, 1, 8'h33, 0);
        step(0, 1, 8'h33, 0);
        reset_n = 1'b1;
        seen_addr.delete();
        for (int i = 0; i < 5; i++) step(0, 1, 8'h44, 0);
        check("t6_ignored_writes", 32'(seen_addr.size()), 32'd0);
        check("t6_busy_idle", {31'd0, busy}, 32'd0);
        step(1, 0, 8'h00, 0);
        send_pixels(3, 1, 0);
        step(0, 0, 8'h00, 1);
        idle(3);
        check("t6_new_first_addr", 32'(seen_addr[0]), 32'd0);
        check("t6_new_count", 32'(seen_addr.size()), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
